// File: rtl/btn_up_down_cond.sv
// btn_up_down_cond: conditions two raw push buttons (up/down) into clean
// one-cycle step pulses plus a qualifying enable strobe for the hour counter.
// Path per button: 2-flop synchroniser -> counter debounce -> shared press/hold FSM.
// Optional feature: define BTN_AUTO_REPEAT_EN to add auto-repeat while a single
// button is held. With it undefined, no repeat counter is built and a press
// yields exactly one step.
module btn_up_down_cond #(
  parameter int DEB_MAX    = 250000,
  parameter int REP_DELAY  = 25000000,
  parameter int REP_PERIOD = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_up,
  input  logic btn_down,
  output logic up,
  output logic down,
  output logic en
);

  localparam int NUM_BTN = 2;
  localparam int DEB_W   = $clog2(DEB_MAX);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_MAX - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_HELD_UP = 2'd1;
  localparam logic [1:0] S_HELD_DN = 2'd2;
  localparam logic [1:0] S_BOTH    = 2'd3;

  // Reject out-of-range parameters at elaboration time.
  if (DEB_MAX < 2 || DEB_MAX > (1 << 20) - 1 ||
      REP_DELAY < 2 || REP_DELAY > (1 << 26) - 1 ||
      REP_PERIOD < 2 || REP_PERIOD > (1 << 26) - 1) begin : g_bad_param
    $error("btn_up_down_cond: parameter out of legal range");
  end

  // Lane 0 = up, lane 1 = down.
  logic [NUM_BTN-1:0] w_raw;
  logic [NUM_BTN-1:0] r_sync1;
  logic [NUM_BTN-1:0] r_sync2;
  logic [NUM_BTN-1:0] w_stb;

  assign w_raw = {btn_down, btn_up};

  // Two-flop synchroniser for both asynchronous button inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_deb
    logic             r_stb;
    logic [DEB_W-1:0] r_cnt;

    // Flip the stable value only after DEB_MAX consecutive differing samples;
    // any agreeing sample restarts the count, so short glitches never land.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_stb <= 1'b0;
        r_cnt <= '0;
      end else if (r_sync2[g] == r_stb) begin
        r_cnt <= '0;
      end else if (r_cnt == DEB_LAST) begin
        r_stb <= ~r_stb;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    assign w_stb[g] = r_stb;
  end

  logic       w_stb_up;
  logic       w_stb_dn;
  logic [1:0] r_state;
  logic [1:0] w_nxt;
  logic       w_up_nxt;
  logic       w_dn_nxt;
  logic       w_rep_hit;
  logic       r_up;
  logic       r_dn;
  logic       r_en;

  assign w_stb_up = w_stb[0];
  assign w_stb_dn = w_stb[1];

`ifdef BTN_AUTO_REPEAT_EN
  localparam int REP_W = 26;
  localparam logic [REP_W-1:0] REP_D_LAST = REP_W'(REP_DELAY - 1);
  localparam logic [REP_W-1:0] REP_P_LAST = REP_W'(REP_PERIOD - 1);

  logic [REP_W-1:0] r_rep_cnt;
  logic             r_rep_per;  // first repeat already issued; now use period

  assign w_rep_hit = r_rep_per ? (r_rep_cnt == REP_P_LAST)
                               : (r_rep_cnt == REP_D_LAST);

  // Repeat timer runs only while staying in a single-held state; any state
  // change (entry or exit) restarts it in the initial-delay phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rep_cnt <= '0;
      r_rep_per <= 1'b0;
    end else if (w_nxt != r_state ||
                 (r_state != S_HELD_UP && r_state != S_HELD_DN)) begin
      r_rep_cnt <= '0;
      r_rep_per <= 1'b0;
    end else if (w_rep_hit) begin
      r_rep_cnt <= '0;
      r_rep_per <= 1'b1;
    end else begin
      r_rep_cnt <= r_rep_cnt + 1'b1;
    end
  end
`else
  assign w_rep_hit = 1'b0;
`endif

  // Press/hold FSM: next state and next-cycle pulse requests.
  always_comb begin
    w_nxt    = r_state;
    w_up_nxt = 1'b0;
    w_dn_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_stb_up && w_stb_dn) begin
          w_nxt = S_BOTH;
        end else if (w_stb_up) begin
          w_nxt    = S_HELD_UP;
          w_up_nxt = 1'b1;
        end else if (w_stb_dn) begin
          w_nxt    = S_HELD_DN;
          w_dn_nxt = 1'b1;
        end
      end
      S_HELD_UP: begin
        if (w_stb_dn)       w_nxt    = S_BOTH;
        else if (!w_stb_up) w_nxt    = S_IDLE;
        else                w_up_nxt = w_rep_hit;
      end
      S_HELD_DN: begin
        if (w_stb_up)       w_nxt    = S_BOTH;
        else if (!w_stb_dn) w_nxt    = S_IDLE;
        else                w_dn_nxt = w_rep_hit;
      end
      S_BOTH: begin
        // Both must clear before a new press counts, so a lingering button
        // never fires on exit.
        if (!w_stb_up && !w_stb_dn) w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  // State and registered outputs; en is registered alongside the pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_up    <= 1'b0;
      r_dn    <= 1'b0;
      r_en    <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_up    <= w_up_nxt;
      r_dn    <= w_dn_nxt;
      r_en    <= w_up_nxt | w_dn_nxt;
    end
  end

  assign up   = r_up;
  assign down = r_dn;
  assign en   = r_en;

endmodule

// File: tb/tb_btn_up_down_cond.sv
// Directed bench for btn_up_down_cond with DEB_MAX=4, REP_DELAY=20, REP_PERIOD=8.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the
// rising edge. Press latency with DEB_MAX=4 is 7 edges.
module tb_btn_up_down_cond;
  localparam int DEB = 4;
  localparam int RD  = 20;
  localparam int RP  = 8;
`ifdef BTN_AUTO_REPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic btn_up;
  logic btn_down;
  logic up;
  logic down;
  logic en;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  btn_up_down_cond #(.DEB_MAX(DEB), .REP_DELAY(RD), .REP_PERIOD(RP)) dut (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down),
    .up(up), .down(down), .en(en)
  );

  typedef struct {
    logic bu;
    logic bd;
    logic eu;
    logic ed;
  } vec_t;

  vec_t tbl[90];

  task automatic chk(input string nm, input int idx, input logic eu, input logic ed);
    total++;
    if ({up, down, en} !== {eu, ed, eu | ed}) begin
      bad++;
      $display("FAIL %s[%0d] got up=%b down=%b en=%b want up=%b down=%b en=%b",
               nm, idx, up, down, en, eu, ed, eu | ed);
    end
  endtask

  // One clock: drive buttons, take the edge, check, return on falling edge.
  task automatic cyc(input logic bu, input logic bd, input logic eu, input logic ed,
                     input string nm, input int idx);
    btn_up   = bu;
    btn_down = bd;
    @(posedge clk);
    #1;
    chk(nm, idx, eu, ed);
    @(negedge clk);
  endtask

  task automatic flush(input string nm, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, nm, i);
  endtask

  initial begin
    logic bu;
    logic bd;
    logic eu;
    logic ed;

    // Clean press: up raw high for 10 edges, single pulse at edge 7.
    for (int r = 0; r < 30; r++) tbl[r] = '{bu: (r < 10), bd: 1'b0, eu: (r == 6), ed: 1'b0};
    // Bounce: 3-high/3-low for 30 cycles, then steady high; pulse 7 edges later.
    for (int r = 0; r < 60; r++)
      tbl[30 + r] = '{bu: 1'b0, bd: (r < 30) ? ((r % 6) < 3) : (r < 46),
                      eu: 1'b0, ed: (r == 36)};

    // Reset asserted from time 0: outputs clear and stay clear.
    rst = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    #1 chk("rst_imm", 0, 1'b0, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 8; i++)
      cyc(1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0, 1'b0, "rst_hold", i);
    rst = 1'b1;
    flush("rst_rel", 10);

    // Table-driven vectors.
    for (int i = 0; i < 90; i++) cyc(tbl[i].bu, tbl[i].bd, tbl[i].eu, tbl[i].ed, "vec", i);

    // Long hold of up: first pulse at edge 7 (T), repeats only with the macro.
    // Raw is released at T+45 so the debounced release lands before T+52.
    for (int k = 1; k <= 6; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0, "ar_pre", k);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, "ar_first", 7);
    for (int k = 1; k <= 70; k++) begin
      bu = (k <= 44);
      eu = AR && (k == RD || k == RD + RP || k == RD + 2 * RP || k == RD + 3 * RP);
      cyc(bu, 1'b0, eu, 1'b0, "ar_hold", k);
    end
    flush("ar_flush", 4);

    // Both buttons: down joins while up held, release down, release up,
    // then a fresh down press gives one pulse 7 edges later.
    for (int k = 1; k <= 6; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0, "both_pre", k);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, "both_first", 7);
    for (int k = 1; k <= 70; k++) begin
      bu = (k < 46);
      bd = (k >= 10 && k < 31) || (k >= 56);
      ed = (k == 62);
      cyc(bu, bd, 1'b0, ed, "both", k);
    end
    flush("both_flush", 12);

    // Reset mid-hold in HELD_UP, button still held through release.
    for (int k = 1; k <= 6; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0, "mh_pre", k);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, "mh_first", 7);
    for (int k = 1; k <= 5; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0, "mh_hold", k);
    rst = 1'b0;
    #1 chk("mh_rst_imm", 0, 1'b0, 1'b0);
    @(negedge clk);
    for (int k = 0; k < 2; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0, "mh_rst", k);
    rst = 1'b1;
    for (int k = 1; k <= 6; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0, "mh_post", k);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, "mh_again", 7);
    flush("mh_flush", 12);

    // Reset asserted while a down pulse is high must clear it without a clock.
    for (int k = 1; k <= 6; k++) cyc(1'b0, 1'b1, 1'b0, 1'b0, "ac_pre", k);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, "ac_pulse", 7);
    rst = 1'b0;
    #1 chk("ac_rst_imm", 0, 1'b0, 1'b0);
    @(negedge clk);
    for (int k = 0; k < 2; k++) cyc(1'b0, 1'b0, 1'b0, 1'b0, "ac_rst", k);
    rst = 1'b1;
    flush("ac_flush", 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
